// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the Pong match sequencer and the ball datapath / VGA overlay.
// master: ball datapath and frame timing side (produces events, consumes control and status).
// slave:  the match sequencer.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       miss_l;
  logic       miss_r;
  logic       paddle_hit;
  logic       ball_run;
  logic       ball_load;
  logic       serve_dir;
  logic [1:0] speed;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  modport master (
    output frame_tick, start_btn, miss_l, miss_r, paddle_hit,
    input  ball_run, ball_load, serve_dir, speed, score_l, score_r,
           game_over, winner, state
  );

  modport slave (
    input  frame_tick, start_btn, miss_l, miss_r, paddle_hit,
    output ball_run, ball_load, serve_dir, speed, score_l, score_r,
           game_over, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game FSM, scores, rally speed level and serve/point timers.
// Timers advance only on frame_tick; all outputs come straight from registers.
// Optional macro PONG_AUTO_SERVE_EN: SERVE moves to PLAY by itself when the countdown
// expires. Without it the countdown expiry arms SERVE and a start button rise launches play.
module pong_match_ctrl #(
  parameter int WIN_SCORE      = 9,
  parameter int SERVE_FRAMES   = 60,
  parameter int POINT_FRAMES   = 30,
  parameter int HITS_PER_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  pong_match_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [3:0] HITS       = 4'(HITS_PER_LEVEL);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic [3:0] hit_next;
  logic [1:0] speed_q, speed_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       ball_load_q, ball_load_d;
  logic       btn_low_q;
  logic       btn_rise;
  logic       serve_expire;
  logic       point_expire;
`ifndef PONG_AUTO_SERVE_EN
  logic       serve_wait_q, serve_wait_d;
`endif

  // The history bit records "button was low last cycle"; it resets to 0 so a button
  // held through reset must first be seen released before it can produce a rise.
  assign btn_rise     = bus.start_btn & btn_low_q;
  assign serve_expire = bus.frame_tick && (frame_cnt_q == SERVE_LAST);
  assign point_expire = bus.frame_tick && (frame_cnt_q == POINT_LAST);

  // State register; illegal encodings are caught by the next-state default.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: timers, scores, speed, serve direction and button history.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      hit_cnt_q    <= '0;
      speed_q      <= '0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      serve_dir_q  <= 1'b1;
      winner_q     <= 1'b0;
      ball_load_q  <= 1'b0;
      btn_low_q    <= 1'b0;
`ifndef PONG_AUTO_SERVE_EN
      serve_wait_q <= 1'b0;
`endif
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      speed_q      <= speed_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      ball_load_q  <= ball_load_d;
      btn_low_q    <= ~bus.start_btn;
`ifndef PONG_AUTO_SERVE_EN
      serve_wait_q <= serve_wait_d;
`endif
    end
  end

  // Next-state and next-register logic; entering SERVE always reloads the ball and
  // clears the countdown, hit counter and speed.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    speed_d      = speed_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    ball_load_d  = 1'b0;
    hit_next     = hit_cnt_q + 4'd1;
`ifndef PONG_AUTO_SERVE_EN
    serve_wait_d = serve_wait_q;
`endif

    case (state_q)
      IDLE: begin
        score_l_d = '0;
        score_r_d = '0;
        speed_d   = '0;
        hit_cnt_d = '0;
        if (btn_rise) begin
          state_d     = SERVE;
          frame_cnt_d = '0;
          ball_load_d = 1'b1;
`ifndef PONG_AUTO_SERVE_EN
          serve_wait_d = 1'b0;
`endif
        end
      end

      SERVE: begin
`ifdef PONG_AUTO_SERVE_EN
        if (bus.frame_tick) frame_cnt_d = frame_cnt_q + 8'd1;
        if (serve_expire) state_d = PLAY;
`else
        if (serve_wait_q) begin
          if (btn_rise) state_d = PLAY;
        end else begin
          if (bus.frame_tick) frame_cnt_d = frame_cnt_q + 8'd1;
          if (serve_expire) begin
            if (btn_rise) state_d = PLAY;
            else          serve_wait_d = 1'b1;
          end
        end
`endif
      end

      PLAY: begin
        if (bus.miss_l) begin
          score_r_d   = score_r_q + 4'd1;
          serve_dir_d = 1'b0;
          frame_cnt_d = '0;
          state_d     = POINT;
        end else if (bus.miss_r) begin
          score_l_d   = score_l_q + 4'd1;
          serve_dir_d = 1'b1;
          frame_cnt_d = '0;
          state_d     = POINT;
        end else if (bus.paddle_hit) begin
          if (hit_next == HITS) begin
            hit_cnt_d = '0;
            if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
          end else begin
            hit_cnt_d = hit_next;
          end
        end
      end

      POINT: begin
        if (bus.frame_tick) frame_cnt_d = frame_cnt_q + 8'd1;
        if (point_expire) begin
          if (score_l_q == WIN) begin
            state_d  = OVER;
            winner_d = 1'b0;
          end else if (score_r_q == WIN) begin
            state_d  = OVER;
            winner_d = 1'b1;
          end else begin
            state_d     = SERVE;
            frame_cnt_d = '0;
            hit_cnt_d   = '0;
            speed_d     = '0;
            ball_load_d = 1'b1;
`ifndef PONG_AUTO_SERVE_EN
            serve_wait_d = 1'b0;
`endif
          end
        end
      end

      OVER: begin
        if (btn_rise) begin
          score_l_d   = '0;
          score_r_d   = '0;
          winner_d    = 1'b0;
          state_d     = SERVE;
          frame_cnt_d = '0;
          hit_cnt_d   = '0;
          speed_d     = '0;
          ball_load_d = 1'b1;
`ifndef PONG_AUTO_SERVE_EN
          serve_wait_d = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.ball_run  = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);
  assign bus.state     = state_q;
  assign bus.ball_load = ball_load_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.speed     = speed_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl: directed reset/button cases followed by random
// per-cycle stimulus, every cycle compared against a rule-level reference model.
// The model follows PONG_AUTO_SERVE_EN the same way the design is built.
module tb_pong_match_ctrl;

  localparam int WIN = 3;
  localparam int SRV = 6;
  localparam int PNT = 4;
  localparam int HPL = 4;

  logic clk;
  logic rst;
  int   nChecks;
  int   nPass;
  int   cycle;

  pong_match_ctrl_if bus ();

  pong_match_ctrl #(
    .WIN_SCORE     (WIN),
    .SERVE_FRAMES  (SRV),
    .POINT_FRAMES  (PNT),
    .HITS_PER_LEVEL(HPL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase numbers follow the published state encodings
  int  mPhase;
  int  mTicks;
  int  mHits;
  int  mScoreL;
  int  mScoreR;
  int  mDir;
  int  mWinner;
  int  mLoad;
  bit  mPrevLow;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed == expected) nPass++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
  endtask

  task automatic enterServe();
    mPhase = 1;
    mTicks = 0;
    mHits  = 0;
    mLoad  = 1;
  endtask

  task automatic modelStep(input bit r, input bit btn, input bit tick,
                           input bit ml, input bit mr, input bit hit);
    bit rise;
    if (r) begin
      mPhase = 0; mTicks = 0; mHits = 0; mScoreL = 0; mScoreR = 0;
      mDir = 1; mWinner = 0; mLoad = 0; mPrevLow = 0;
      return;
    end
    rise     = btn && mPrevLow;
    mPrevLow = !btn;
    mLoad    = 0;
    case (mPhase)
      0: if (rise) enterServe();
      1: begin
        if (tick) mTicks++;
`ifdef PONG_AUTO_SERVE_EN
        if (mTicks >= SRV) mPhase = 2;
`else
        if (mTicks >= SRV && rise) mPhase = 2;
`endif
      end
      2: begin
        if (ml) begin
          mScoreR++; mDir = 0; mPhase = 3; mTicks = 0;
        end else if (mr) begin
          mScoreL++; mDir = 1; mPhase = 3; mTicks = 0;
        end else if (hit) begin
          mHits++;
        end
      end
      3: begin
        if (tick) mTicks++;
        if (mTicks >= PNT) begin
          if (mScoreL == WIN)      begin mPhase = 4; mWinner = 0; end
          else if (mScoreR == WIN) begin mPhase = 4; mWinner = 1; end
          else enterServe();
        end
      end
      default: if (rise) begin
        mScoreL = 0; mScoreR = 0; mWinner = 0;
        enterServe();
      end
    endcase
  endtask

  task automatic applyStimulus(input bit r, input bit btn, input bit tick,
                               input bit ml, input bit mr, input bit hit);
    int expSpeed;
    rst            = r;
    bus.start_btn  = btn;
    bus.frame_tick = tick;
    bus.miss_l     = ml;
    bus.miss_r     = mr;
    bus.paddle_hit = hit;
    modelStep(r, btn, tick, ml, mr, hit);
    @(posedge clk);
    #1;
    cycle++;
    expSpeed = (mHits / HPL > 3) ? 3 : mHits / HPL;
    checkOutput("state",     int'(bus.state),     mPhase);
    checkOutput("ball_run",  int'(bus.ball_run),  (mPhase == 2) ? 1 : 0);
    checkOutput("ball_load", int'(bus.ball_load), mLoad);
    checkOutput("serve_dir", int'(bus.serve_dir), mDir);
    checkOutput("speed",     int'(bus.speed),     expSpeed);
    checkOutput("score_l",   int'(bus.score_l),   mScoreL);
    checkOutput("score_r",   int'(bus.score_r),   mScoreR);
    checkOutput("game_over", int'(bus.game_over), (mPhase == 4) ? 1 : 0);
    checkOutput("winner",    int'(bus.winner),    mWinner);
  endtask

  // main sequence: directed prologue, then random play
  initial begin
    bit btn;
    bit tick;
    bit ml;
    bit mr;
    bit hit;
    bit r;
    int roll;
    nChecks = 0;
    nPass   = 0;
    cycle   = 0;
    btn     = 1'b0;

    // reset with the button held: no serve may start until it is released and pressed
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);

    // walk through the countdown, then launch play
    for (int i = 0; i < SRV + 3; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    // thirteen hits in one rally, then both misses together
    for (int i = 0; i < 13; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < PNT + 2; i++) applyStimulus(0, 0, 1, 0, 0, 0);

    // random play with occasional resets
    for (int n = 0; n < 12000; n++) begin
      if ($urandom_range(0, 7) == 0) btn = !btn;
      tick = ($urandom_range(0, 2) == 0);
      hit  = ($urandom_range(0, 4) == 0);
      roll = $urandom_range(0, 99);
      ml   = (roll < 2) || (roll == 4);
      mr   = (roll >= 2 && roll < 5);
      r    = ($urandom_range(0, 1999) == 0);
      applyStimulus(r, btn, tick, ml, mr, hit);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong datapath. Owns the game state machine (idle, serve countdown, rally, point pause, game over), both players' scores and the rally speed level. It gates and reloads the ball-motion datapath and feeds scores and status to the VGA overlay. It runs in the pixel-clock domain and advances its timers only on the per-frame tick.

## Interface
Parameters:
- `WIN_SCORE`, 9: points needed to win; legal range 1..15.
- `SERVE_FRAMES`, 60: frames of serve countdown; legal range 1..255.
- `POINT_FRAMES`, 30: frames of freeze after a point; legal range 1..255.
- `HITS_PER_LEVEL`, 4: paddle hits per speed step; legal range 1..15.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per frame (start of vblank).
- `start_btn`  in  1  level, already synchronized; only rising edges are used.
- `miss_l`  in  1  one-cycle pulse: ball passed the left edge, so the right player scores.
- `miss_r`  in  1  one-cycle pulse: ball passed the right edge, so the left player scores.
- `paddle_hit`  in  1  one-cycle pulse: ball bounced off either paddle.
- `ball_run`  out  1  enables ball motion.
- `ball_load`  out  1  one-cycle pulse: reload ball to centre with `serve_dir`.
- `serve_dir`  out  1  0 = serve toward left, 1 = serve toward right.
- `speed`  out  2  rally speed level, 0..3.
- `score_l`, `score_r`  out  4 each  player scores.
- `game_over`  out  1  high while in OVER.
- `winner`  out  1  0 = left, 1 = right; valid while `game_over` is high.
- `state`  out  3  FSM encoding, for debug.

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Encodings 5..7 recover to IDLE on the next clock.
- `btn_rise` = `start_btn` AND NOT (`start_btn` registered one cycle earlier).
- IDLE:
  - Scores, `speed` and the hit counter are held at 0.
  - On `btn_rise`: go to SERVE and pulse `ball_load`.
- SERVE:
  - `ball_run`=0. The frame counter is cleared on entry and increments on each `frame_tick`.
  - Countdown expires on the `frame_tick` where counter == `SERVE_FRAMES`-1.
  - Exit to PLAY is defined under Configuration.
  - `speed` and the hit counter are cleared on entry.
- PLAY:
  - `ball_run`=1.
  - `miss_l`: `score_r`+1, `serve_dir`=0, go to POINT.
  - `miss_r`: `score_l`+1, `serve_dir`=1, go to POINT.
  - `paddle_hit`: the hit counter increments. When it reaches `HITS_PER_LEVEL`, it clears and `speed` increments, saturating at 3.
- POINT:
  - `ball_run`=0. The frame counter is cleared on entry and counts `POINT_FRAMES` ticks, same rule as SERVE.
  - On expiry: if either score == `WIN_SCORE`, go to OVER with `winner` set to that player.
  - Otherwise go to SERVE and pulse `ball_load`.
- OVER:
  - `game_over`=1. Scores are held for display.
  - On `btn_rise`: clear scores and `winner`, go to SERVE, pulse `ball_load`.
- Simultaneous events in PLAY:
  - `miss_l` beats `miss_r`; the ignored miss is dropped.
  - A miss beats `paddle_hit` in the same cycle; the hit is not counted.
- Events outside PLAY: misses and hits are ignored; scores cannot change outside PLAY.
- Scores never exceed `WIN_SCORE`; no 4-bit wrap is possible within the legal parameter range.

## Timing
- Every output is a registered function of state or registers. State changes one cycle after the qualifying input.
- `ball_load` is high only in the first cycle of SERVE: exactly one cycle per entry.
- `ball_run` rises in the cycle after the expiring `frame_tick`, or after the qualifying `btn_rise` in manual mode. It falls in the cycle after the miss pulse.
- A score update is visible in the same cycle `state` shows POINT.
- Reset values: state IDLE, `ball_run`=0, `ball_load`=0, `serve_dir`=1, `speed`=0, `score_l`=0, `score_r`=0, `game_over`=0, `winner`=0, counters 0, button history 0.
- A reset asserted mid-rally takes effect on the next clock and overrides all inputs.
- A button held high through reset does not produce `btn_rise`.
- `frame_tick` in the same cycle as a state entry does not count toward the new state's timer.

## Configuration
- `PONG_AUTO_SERVE_EN` defined:
  - SERVE goes to PLAY automatically on countdown expiry.
  - `start_btn` is used only in IDLE and OVER.
- `PONG_AUTO_SERVE_EN` undefined:
  - After the countdown expires, SERVE waits for `btn_rise` before going to PLAY.
  - A `btn_rise` arriving before expiry is ignored.
  - Countdown expiry and `btn_rise` in the same cycle: go to PLAY.

## Test plan
- Reset, then assert `rst` for 1 cycle during PLAY -> next cycle all outputs are at reset values and state=0.
- With auto-serve: `btn_rise` in IDLE -> exactly one `ball_load` cycle; state=2 one cycle after the 60th `frame_tick`.
- In PLAY, `miss_l` and `miss_r` asserted in the same cycle -> `score_r`=1, `score_l`=0, `serve_dir`=0, state=3; POINT lasts 30 ticks, then SERVE.
- 13 `paddle_hit` pulses in one rally -> `speed` 0→1 at hit 4, →2 at hit 8, →3 at hit 12, stays 3 at hit 13; resets to 0 at the next SERVE.
- `WIN_SCORE`=2, two `miss_r` rallies -> after the second POINT expires: state=4, `game_over`=1, `winner`=0, `score_l`=2; `btn_rise` -> scores 0 and `ball_load` pulse.
- Without the macro: countdown expires with no button -> stays in SERVE for 100 further ticks with `ball_run`=0; `btn_rise` -> PLAY on the next cycle.
